// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, synchronous clear and clamped load.
// Define CNT_SATURATE_EN to hold at the count limits instead of wrapping.
module mod_counter #(
    parameter int WIDTH    = 12,
    parameter int MODULUS  = 4096,
    parameter int PRESCALE = 1,
    parameter int PS_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);

`ifdef CNT_SATURATE_EN
    localparam logic [WIDTH-1:0] UP_LIMIT = CNT_MAX;
    localparam logic [WIDTH-1:0] DN_LIMIT = '0;
`else
    localparam logic [WIDTH-1:0] UP_LIMIT = '0;
    localparam logic [WIDTH-1:0] DN_LIMIT = CNT_MAX;
`endif

    logic [PS_W-1:0]  ps;
    logic [PS_W-1:0]  ps_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             lerr_nxt;
    logic             tick;
    logic             at_max;
    logic             at_min;

    // With PRESCALE==1 the compare is against zero and ps never leaves 0.
    assign tick   = en && (ps == PS_MAX);
    assign at_max = (count == CNT_MAX);
    assign at_min = (count == '0);

    always_comb begin
        ps_nxt   = ps;
        cnt_nxt  = count;
        tc_nxt   = 1'b0;
        lerr_nxt = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
            ps_nxt  = '0;
        end else if (load) begin
            ps_nxt = '0;
            if (load_val > CNT_MAX) begin
                cnt_nxt  = CNT_MAX;
                lerr_nxt = 1'b1;
            end else begin
                cnt_nxt = load_val;
            end
        end else if (en) begin
            ps_nxt = (ps == PS_MAX) ? '0 : ps + PS_ONE;
            if (tick) begin
                if (up_dn) begin
                    if (at_max) begin
                        cnt_nxt = UP_LIMIT;
                        tc_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = count + CNT_ONE;
                    end
                end else begin
                    if (at_min) begin
                        cnt_nxt = DN_LIMIT;
                        tc_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = count - CNT_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps       <= '0;
            count    <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            ps       <= ps_nxt;
            count    <= cnt_nxt;
            tc       <= tc_nxt;
            load_err <= lerr_nxt;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: vector table, corner sequences and random run
// against an integer reference model (PRESCALE=3 and PRESCALE=1 instances).
module tb_mod_counter;

    localparam int W = 4;
    localparam int M = 10;
    localparam int P = 3;
`ifdef CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count_a;
    logic [W-1:0] count_b;
    logic         tc_a;
    logic         tc_b;
    logic         lerr_a;
    logic         lerr_b;

    mod_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(P), .PS_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .count(count_a), .tc(tc_a), .load_err(lerr_a)
    );

    mod_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1), .PS_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .count(count_b), .tc(tc_b), .load_err(lerr_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per instance, count value and enabled cycles since clear/load.
    int m_cnt[2];
    int m_ecnt[2];
    int m_tc[2];
    int m_lerr[2];
    int pres[2] = '{P, 1};

    typedef struct {
        logic         c;
        logic         l;
        logic         e;
        logic         u;
        logic [W-1:0] lv;
        int           cnt;
        int           tc;
        int           lerr;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t v(input logic c, input logic l, input logic e,
                               input logic u, input int lv, input int cnt,
                               input int tc, input int lerr);
        vec_t r;
        r.c = c; r.l = l; r.e = e; r.u = u;
        r.lv = W'(lv); r.cnt = cnt; r.tc = tc; r.lerr = lerr;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ecnt[k] = 0; m_tc[k] = 0; m_lerr[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_tc[k] = 0;
            m_lerr[k] = 0;
            if (clr) begin
                m_cnt[k] = 0;
                m_ecnt[k] = 0;
            end else if (load) begin
                m_ecnt[k] = 0;
                if (int'(load_val) >= M) begin
                    m_cnt[k] = M - 1;
                    m_lerr[k] = 1;
                end else begin
                    m_cnt[k] = int'(load_val);
                end
            end else if (en) begin
                m_ecnt[k]++;
                if (m_ecnt[k] % pres[k] == 0) begin
                    if (up_dn) begin
                        if (m_cnt[k] == M - 1) begin
                            m_tc[k] = 1;
                            m_cnt[k] = SAT ? M - 1 : 0;
                        end else m_cnt[k]++;
                    end else begin
                        if (m_cnt[k] == 0) begin
                            m_tc[k] = 1;
                            m_cnt[k] = SAT ? 0 : M - 1;
                        end else m_cnt[k]--;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        check("a.count", int'(count_a), m_cnt[0]);
        check("a.tc", int'(tc_a), m_tc[0]);
        check("a.load_err", int'(lerr_a), m_lerr[0]);
        check("b.count", int'(count_b), m_cnt[1]);
        check("b.tc", int'(tc_b), m_tc[1]);
        check("b.load_err", int'(lerr_b), m_lerr[1]);
        check("a.range", int'(count_a < W'(M)), 1);
    endtask

    task automatic cyc(input logic c, input logic l, input logic e,
                       input logic u, input logic [W-1:0] lv);
        clr = c; load = l; en = e; up_dn = u; load_val = lv;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        // Expected values for the PRESCALE=3 instance, starting from reset.
        tbl[0]  = v(0, 1, 0, 1, 12, 9, 0, 1);
        tbl[1]  = v(0, 0, 1, 1, 0, 9, 0, 0);
        tbl[2]  = v(0, 0, 1, 1, 0, 9, 0, 0);
        tbl[3]  = v(0, 0, 1, 1, 0, SAT ? 9 : 0, 1, 0);
        tbl[4]  = v(0, 0, 0, 1, 0, SAT ? 9 : 0, 0, 0);
        tbl[5]  = v(0, 1, 1, 1, 5, 5, 0, 0);
        tbl[6]  = v(0, 0, 1, 0, 0, 5, 0, 0);
        tbl[7]  = v(0, 0, 1, 0, 0, 5, 0, 0);
        tbl[8]  = v(0, 0, 1, 0, 0, 4, 0, 0);
        tbl[9]  = v(1, 1, 1, 0, 3, 0, 0, 0);
        tbl[10] = v(0, 0, 1, 0, 0, 0, 0, 0);
        tbl[11] = v(0, 0, 1, 0, 0, 0, 0, 0);
        tbl[12] = v(0, 0, 1, 0, 0, SAT ? 0 : 9, 1, 0);
        tbl[13] = v(0, 0, 1, 0, 0, SAT ? 0 : 9, 0, 0);
        tbl[14] = v(0, 0, 1, 0, 0, SAT ? 0 : 9, 0, 0);
        tbl[15] = v(0, 0, 1, 0, 0, SAT ? 0 : 8, SAT ? 1 : 0, 0);
        tbl[16] = v(0, 1, 0, 1, 9, 9, 0, 0);
        tbl[17] = v(0, 0, 1, 1, 0, 9, 0, 0);
        tbl[18] = v(0, 0, 1, 1, 0, 9, 0, 0);
        tbl[19] = v(1, 1, 1, 1, 12, 0, 0, 0);

        model_reset();
        @(posedge clk);
        #1;
        check("reset.count", int'(count_a), 0);
        check("reset.tc", int'(tc_a), 0);
        check("reset.load_err", int'(lerr_a), 0);
        check("reset.count_b", int'(count_b), 0);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].lv);
            check($sformatf("vec%0d.count", i), int'(count_a), tbl[i].cnt);
            check($sformatf("vec%0d.tc", i), int'(tc_a), tbl[i].tc);
            check($sformatf("vec%0d.load_err", i), int'(lerr_a), tbl[i].lerr);
        end

        // Ten steps upward from zero land on the limit.
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, 1, 1, 0);
        check("uprun.count", int'(count_a), SAT ? 9 : 0);
        check("uprun.tc", int'(tc_a), 1);

        // Enable dropped for 5 cycles mid-prescale delays the step by 5.
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        check("gap.before", int'(count_a), 0);
        cyc(0, 0, 1, 1, 0);
        check("gap.step", int'(count_a), 1);

        // Up from 8 and down from 1 across the limits.
        cyc(0, 1, 0, 1, 8);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 1, 0);
        check("from8.count", int'(count_a), SAT ? 9 : 1);
        check("from8.tc", int'(tc_a), SAT ? 1 : 0);
        cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);
        check("from1.count", int'(count_a), SAT ? 0 : 9);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("from1.hold", int'(count_a), SAT ? 0 : 8);

        // Asynchronous reset between edges while count is 7.
        cyc(0, 1, 0, 1, 7);
        cyc(0, 0, 1, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        check("areset.count", int'(count_a), 0);
        check("areset.tc", int'(tc_a), 0);
        check("areset.count_b", int'(count_b), 0);
        model_reset();
        #3 reset_n = 1'b1;

        // Reset just before a wrapping step leaves no tc behind.
        cyc(0, 1, 0, 1, 9);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("areset2.tc", int'(tc_a), 0);
        check("areset2.count", int'(count_a), 0);
        model_reset();
        #3 reset_n = 1'b1;

        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 31) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                W'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
